// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // MAX_HOLD value meaning a burst is never cut short
    localparam int unsigned HOLD_UNLIMITED = 0;

    // Upper bound on requester count supported by onehot_to_idx
    localparam int unsigned ARB_MAX_REQ = 64;

    function automatic logic [31:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
        logic [ARB_MAX_REQ-1:0] v;
        logic [31:0]            idx;
        v   = oh;
        idx = '0;
        for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
            if (v[0]) idx = i;
            v = v >> 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Masked priority encoder: first set request at or after ptr_i (wrapping) wins.
// RR_ARBITER_FIXED_MODE_EN adds fixed_pri_i: highest set index wins instead.
module arb_rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
`ifdef RR_ARBITER_FIXED_MODE_EN
    input  logic               fixed_pri_i,
`endif
    output logic [NUM_REQ-1:0] win_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        pos   = ptr_i;
`ifdef RR_ARBITER_FIXED_MODE_EN
        if (fixed_pri_i) begin
            pos = LAST;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && req_i[pos]) begin
                    win_o[pos] = 1'b1;
                    found      = 1'b1;
                end
                pos = pos - IDX_W'(1);
            end
        end else
`endif
        begin
            // Explicit wrap keeps non-power-of-two NUM_REQ in range
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && req_i[pos]) begin
                    win_o[pos] = 1'b1;
                    found      = 1'b1;
                end
                pos = (pos == LAST) ? '0 : pos + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with burst hold limit and registered one-hot grants.
// Optional RR_ARBITER_FIXED_MODE_EN adds fixed_pri for legacy fixed priority.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = 4,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
`ifdef RR_ARBITER_FIXED_MODE_EN
    input  logic               fixed_pri,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    localparam int unsigned HC_W = (MAX_HOLD == HOLD_UNLIMITED) ? 8 : $clog2(MAX_HOLD + 1);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [HC_W-1:0]    hold_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               valid_q;

    logic               fixed;
    logic [IDX_W-1:0]   ptr_after;
    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0]   win_idx;
    logic               timeout;
    logic               keep;

`ifdef RR_ARBITER_FIXED_MODE_EN
    assign fixed = fixed_pri;
`else
    assign fixed = 1'b0;
`endif

    assign ptr_after = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    // While granted, pick with the post-release pointer so handoff has no bubble
    assign pick_ptr  = (state_q == ARB_GRANT) ? ptr_after : ptr_q;
    assign timeout   = (MAX_HOLD != HOLD_UNLIMITED) && (hold_q >= HC_W'(MAX_HOLD));
    assign keep      = req[idx_q] && !timeout;
    assign win_idx   = IDX_W'(onehot_to_idx(ARB_MAX_REQ'(win)));

    arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i       (req),
        .ptr_i       (pick_ptr),
`ifdef RR_ARBITER_FIXED_MODE_EN
        .fixed_pri_i (fixed_pri),
`endif
        .win_o       (win)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (!en) begin
            if (state_q == ARB_GRANT && !fixed) ptr_q <= ptr_after;
            state_q <= ARB_IDLE;
            hold_q  <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (win != '0) begin
                        state_q <= ARB_GRANT;
                        gnt_q   <= win;
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        hold_q  <= HC_W'(1);
                    end
                end
                ARB_GRANT: begin
                    if (keep) begin
                        if (hold_q != '1) hold_q <= hold_q + HC_W'(1);
                    end else begin
                        if (!fixed) ptr_q <= ptr_after;
                        if (win != '0) begin
                            gnt_q  <= win;
                            idx_q  <= win_idx;
                            hold_q <= HC_W'(1);
                        end else begin
                            state_q <= ARB_IDLE;
                            gnt_q   <= '0;
                            valid_q <= 1'b0;
                            hold_q  <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule
